countdown_timer_bcd: RTL
========================

# countdown_timer_bcd

Parametrised coin-operated countdown timer with BCD minute and second digits, a built-in one-second prescaler, and a run/pause/clear control FSM. It replaces hard-wired cascaded digit counters in the vending/timer datapath. It feeds the seven-segment display drivers and signals the control logic when time has expired.

## Interface
- MIN_DIGITS, 1: number of BCD minute digits (1 or 2); maximum minutes are 9 or 99.
- TICK_DIV, 50000000: Clk cycles per one-second tick; must be at least 2.
- Clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse, coin inserted.
- Pause  in  1  level; holds the count while high.
- Clear  in  1  synchronous abort to IDLE.
- PresetMin  in  4*MIN_DIGITS  BCD minutes loaded on Start.
- Min  out  4*MIN_DIGITS  BCD minutes remaining.
- SecTens  out  4  BCD tens of seconds, 0..5.
- SecOnes  out  4  BCD ones of seconds, 0..9.
- Running  out  1  high in RUN.
- Busy  out  1  high in RUN or PAUSE.
- Done  out  1  one-cycle pulse on expiry.

## Operation
- Reset values: all digits 0, Running=0, Busy=0, Done=0, prescaler 0, state IDLE.
- States: IDLE, RUN, PAUSE.
- IDLE, Start=1:
  - Load Min=PresetMin, SecTens=0, SecOnes=0, and clear the prescaler.
  - Go to PAUSE if Pause=1, otherwise to RUN.
  - If PresetMin is 0, Start is ignored and the block stays in IDLE.
- PresetMin digit above 9: the digit is clamped to 9.
- RUN → PAUSE when Pause=1. PAUSE → RUN when Pause=0. The prescaler value is retained across PAUSE.
- Prescaler: advances only in RUN and counts 0..TICK_DIV-1. Tick is asserted when it is at TICK_DIV-1; it then wraps to 0.
- Tick: decrements M:SS by one second with BCD borrow, e.g. 1:00 → 0:59 and 10:00 → 9:59.
- Expiry: a tick that produces 0:00 moves the state to IDLE and asserts Done for the next cycle only. The digits remain 0:00.
- Clear=1 in any state:
  - Digits go to 0 and the state goes to IDLE.
  - Done is not asserted.
  - Clear has priority over Start, Pause and tick.
- Start while RUN or PAUSE: behaviour depends on the Configuration section.
- Out-of-range digits are never produced.

## Timing
- Register outputs: every output is registered.
- Start latency: Start sampled at edge k makes Min/Sec and Running valid after edge k.
- First tick: the first decrement occurs TICK_DIV cycles after the load edge, assuming no pause.
- Done timing: Done goes high on the edge after the final decrement and stays high for exactly one cycle. Running falls on that same edge.
- Full run length: a preset of P minutes with no pause takes exactly P*60*TICK_DIV cycles from load to the edge that produces 0:00.
- Asynchronous reset: nReset low mid-operation clears everything immediately, with no Done pulse.

## Configuration
- COUNTDOWN_ADD_TIME_EN defined: Start in RUN or PAUSE adds PresetMin (clamped) to Min using BCD addition.
  - Seconds are unchanged and the state is unchanged.
  - Min saturates at all-nines (9 or 99).
  - Start together with a tick applies the decrement first, then the add.
  - If the decrement reached 0:00 in that same cycle, the add wins: there is no Done, and the timer continues from PresetMin:00.
- COUNTDOWN_ADD_TIME_EN not defined: Start is ignored outside IDLE.

## Test plan
All scenarios use MIN_DIGITS=1 and TICK_DIV=4.
- Reset and load:
  - nReset low → all digits 0, Running=0, Busy=0, Done=0.
  - Release reset, pulse Start with PresetMin=1 → 1:00 and Running=1 on the next edge.
- Full countdown:
  - 4 cycles after the load edge → 0:59.
  - 240 cycles after the load edge → 0:00, Done high for exactly 1 cycle, Running=0.
- Pause:
  - At 0:45 with the prescaler at 2, hold Pause for 20 cycles → display stays 0:45 and Busy=1.
  - Release Pause → 0:44 arrives exactly 2 cycles after release.
- Add time, macro on:
  - At 0:30, Start with PresetMin=3 → 3:30.
  - Then Start with PresetMin=9 → 9:30 (saturated).
  - Macro off: the display is unchanged by these Starts.
- Abort:
  - Clear at 0:10 → 0:00, IDLE, Done never asserted.
  - nReset pulsed mid-run → same result, applied asynchronously.
- Preset edges:
  - Start with PresetMin=0 → stays IDLE, Running=0.
  - Start with PresetMin=4'hC → loads 9:00.

Source files
------------

// File: rtl/countdown_timer_bcd.sv
// BCD M:SS countdown timer with built-in one-second prescaler and IDLE/RUN/PAUSE control.
// Define COUNTDOWN_ADD_TIME_EN to let Start in RUN/PAUSE add PresetMin to the remaining minutes.
module countdown_timer_bcd #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                    Clk,
    input  logic                    nReset,
    input  logic                    Start,
    input  logic                    Pause,
    input  logic                    Clear,
    input  logic [4*MIN_DIGITS-1:0] PresetMin,
    output logic [4*MIN_DIGITS-1:0] Min,
    output logic [3:0]              SecTens,
    output logic [3:0]              SecOnes,
    output logic                    Running,
    output logic                    Busy,
    output logic                    Done
);

    localparam int              MW        = 4 * MIN_DIGITS;
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0]   MIN_FULL  = {MIN_DIGITS{4'd9}};

`ifdef COUNTDOWN_ADD_TIME_EN
    localparam bit ADD_TIME_EN = 1'b1;
`else
    localparam bit ADD_TIME_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } stateT;

    stateT           state;
    stateT           stateNext;
    logic [PW-1:0]   presc;
    logic [PW-1:0]   prescNext;
    logic [MW-1:0]   minNext;
    logic [3:0]      tensNext;
    logic [3:0]      onesNext;
    logic [MW-1:0]   presetClamped;
    logic            presetValid;
    logic            tick;
    logic            expire;

    // Any BCD digit above 9 is treated as 9.
    function automatic logic [MW-1:0] clampBcd(input logic [MW-1:0] v);
        logic [MW-1:0] r;
        r = v;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Minutes minus one with BCD borrow; only called with a non-zero value.
    function automatic logic [MW-1:0] decBcd(input logic [MW-1:0] v);
        logic [MW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD sum that saturates at all-nines instead of wrapping.
    function automatic logic [MW-1:0] addBcdSat(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [MW-1:0] r;
        logic          carry;
        logic [4:0]    s;
        r     = '0;
        carry = 1'b0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
            if (s > 5'd9) begin
                r[4*i +: 4] = 4'(s - 5'd10);
                carry       = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                carry       = 1'b0;
            end
        end
        return carry ? MIN_FULL : r;
    endfunction

    assign presetClamped = clampBcd(PresetMin);
    assign presetValid   = |presetClamped;
    assign tick          = (state == RUN) && (presc == PRESC_MAX);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path can hold a stale value and infer a latch.
        stateNext = state;
        prescNext = presc;
        minNext   = Min;
        tensNext  = SecTens;
        onesNext  = SecOnes;
        expire    = 1'b0;

        if (Clear) begin
            stateNext = IDLE;
            prescNext = '0;
            minNext   = '0;
            tensNext  = 4'd0;
            onesNext  = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start && presetValid) begin
                        minNext   = presetClamped;
                        tensNext  = 4'd0;
                        onesNext  = 4'd0;
                        prescNext = '0;
                        stateNext = Pause ? PAUSE : RUN;
                    end
                end

                RUN, PAUSE: begin
                    if (state == RUN) prescNext = tick ? '0 : presc + PW'(1);

                    if (tick) begin
                        if (SecOnes != 4'd0) begin
                            onesNext = SecOnes - 4'd1;
                        end else begin
                            onesNext = 4'd9;
                            if (SecTens != 4'd0) begin
                                tensNext = SecTens - 4'd1;
                            end else begin
                                tensNext = 4'd5;
                                minNext  = decBcd(Min);
                            end
                        end
                        expire = (minNext == '0) && (tensNext == 4'd0) && (onesNext == 4'd0);
                    end

                    // Added time applies after the decrement and rescues an expiry in the same cycle.
                    if (ADD_TIME_EN && Start && presetValid) begin
                        minNext = addBcdSat(minNext, presetClamped);
                        expire  = 1'b0;
                    end

                    if (expire)     stateNext = IDLE;
                    else if (Pause) stateNext = PAUSE;
                    else            stateNext = RUN;
                end

                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            presc   <= '0;
            Min     <= '0;
            SecTens <= 4'd0;
            SecOnes <= 4'd0;
            Running <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            state   <= stateNext;
            presc   <= prescNext;
            Min     <= minNext;
            SecTens <= tensNext;
            SecOnes <= onesNext;
            Running <= (stateNext == RUN);
            Busy    <= (stateNext != IDLE);
            Done    <= expire;
        end
    end

endmodule
